noc_request_axi: RTL and testbench
==================================

# noc_request_axi

Request-side bridge from the AXI master port of the accelerator to the OpenPiton NoC. It converts AXI INCR bursts on AR, and on AW plus W, into OpenPiton non-cacheable load and store request messages, one message per 8-byte AXI beat. For every message it pushes a 6-bit transaction-info word into the type FIFO consumed by `noc_response_axi`, so responses can be decoded in order.

## Interface
- `AXI_ADDR_WIDTH`, 64: AXI address width; the NoC carries only `addr[47:0]`.
- `AXI_DATA_WIDTH`, 64: fixed at 64; one beat is one 8-byte message.
- `DEST_CHIPID` / `DEST_X` / `DEST_Y`, 14'd0 / 8'd0 / 8'd0: destination L2 tile.
- `SRC_CHIPID` / `SRC_X` / `SRC_Y`, 14'd0 / 8'd0 / 8'd0: this tile, used in header 2.
- `MSHRID`, 8'd0: MSHR id placed in header 0.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axi_araddr` in AXI_ADDR_WIDTH; `s_axi_arlen` in 8; `s_axi_arvalid` in 1; `s_axi_arready` out 1: AR channel. arsize is fixed at 3 and the port is not present.
- `s_axi_awaddr` in AXI_ADDR_WIDTH; `s_axi_awlen` in 8; `s_axi_awvalid` in 1; `s_axi_awready` out 1: AW channel.
- `s_axi_wdata` in 64; `s_axi_wlast` in 1; `s_axi_wvalid` in 1; `s_axi_wready` out 1: W channel. Strobes are not present; every beat is a full 8 bytes.
- `noc_valid_out` out 1; `noc_data_out` out 64; `noc_ready_in` in 1: NoC request channel.
- `transaction_type_wr_data` out 6; `transaction_type_wr` out 1; `transaction_type_full` in 1: type-FIFO write port.

## Operation
- **States:** IDLE, RD_H0, RD_H1, RD_H2, WR_H0, WR_H1, WR_H2, WR_DATA.
- **Flit handshake:** a flit moves when `noc_valid_out && noc_ready_in`. `noc_valid_out` is 1 in every state except IDLE. It is 0 in RD_H0 and WR_H0 while `transaction_type_full` is high, and 0 in WR_H0 while `s_axi_wvalid` is low.
- **Arbitration in IDLE:**
  - Only `arvalid` high: grant read. Only `awvalid` high: grant write.
  - Both high: grant the opposite of the last grant. The last-grant register resets to "write", so the first conflict goes to read.
  - A grant pulses `arready` or `awready` for one cycle and latches address, len and beat counter = 0. Next state is RD_H0 or WR_H0.
  - A granted burst runs to completion before the next arbitration.
- **Header 0:**
  - [63:50] DEST_CHIPID, [49:42] DEST_X, [41:34] DEST_Y, [33:30] 0.
  - [29:22] length: 2 for a load, 3 for a store.
  - [21:14] msg_type: 8'd14 for NC load, 8'd15 for NC store.
  - [13:6] MSHRID, [5:0] 0.
- **Header 1:** [63:16] beat address[47:0]; [13:11] = 3'b100 (8 B); all other bits 0.
- **Header 2:** [63:50] SRC_CHIPID, [49:42] SRC_X, [41:34] SRC_Y; all other bits 0.
- **Store data flit:** `wdata` byte-reversed. `noc_data_out[63:56] = wdata[7:0]` through `noc_data_out[7:0] = wdata[63:56]`.
- **Type-FIFO write:** `transaction_type_wr` pulses in the cycle header 0 is accepted.
  - Word layout: {last_write_flit, last_read_transfer, read_size=0, word_select, type}.
  - word_select = beat address[3]; it is 0 for stores.
  - type: 2'd1 for a load, 2'd2 for a store.
  - last_read_transfer = 1 on the final read beat; it is 0 for stores.
  - last_write_flit = `s_axi_wlast`; it is 0 for loads.
- **Read beat sequence:** RD_H0 → RD_H1 → RD_H2.
  - After RD_H2 is accepted: if beat counter == len, go to IDLE; otherwise increment the counter, add 8 to the address and return to RD_H0.
- **Write beat sequence:** WR_H0 → WR_H1 → WR_H2 → WR_DATA.
  - `s_axi_wready` = 1 only in WR_DATA, and equals `noc_ready_in` there, so W handshakes exactly when the data flit moves.
  - After WR_DATA: if beat counter == len, go to IDLE; otherwise go to WR_H0 with the address advanced by 8.
  - `wlast` is not used to terminate the burst; a `wlast` mismatch is a master error and is not checked.
- **Address arithmetic:** the address register is AXI_ADDR_WIDTH bits and wraps modulo 2^AXI_ADDR_WIDTH. There is no 4 KiB boundary check. The beat counter is 8 bits, so len 255 gives 256 beats.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Reset asserted mid-burst aborts immediately: outputs drop asynchronously and the partial burst is discarded with no cleanup flits.
- **Latency:** with `noc_ready_in` held high, the first header 0 is presented the cycle after the AR/AW handshake.
  - Reads run at 3 cycles per beat; writes at 4 cycles per beat.
  - IDLE costs 1 cycle between bursts.
- **Back-pressure:** `noc_data_out` is stable while `noc_valid_out && !noc_ready_in`. `noc_valid_out` is never withdrawn once raised, except by reset.
- **Type-FIFO full:** when `transaction_type_full` is high in RD_H0 or WR_H0, the state holds with valid low. Headers 1, 2 and data are never blocked by it.
- **Simultaneous ARVALID/AWVALID in IDLE:** exactly one ready pulses, per the arbitration rule.

## Test plan
- **Single read:** AR addr 0x1000, len 0 → three flits.
  - H0 length 2, type 14; H1[63:16] = 0x1000; H2 carries the source fields.
  - Type word 6'b010001 is written once.
- **Read burst:** AR addr 0x2008, len 3 → four messages with addresses 0x2008, 0x2010, 0x2018, 0x2020.
  - Type words: 6'b000101, 6'b000001, 6'b000101, then 6'b010001.
  - Total 12 cycles with ready high.
- **Write burst:** AW 0x3000, len 1; W beats 0x0102030405060708, then 0x1112131415161718 with last.
  - Data flits 0x0807060504030201 and 0x1817161514131211.
  - Type words 6'b000010, then 6'b100010.
  - `wready` pulses exactly twice.
- **Arbitration:** AR and AW valid in the same cycle, twice in a row → read is granted first, then write.
- **Back-pressure and full:** toggle `noc_ready_in` randomly and hold `transaction_type_full` high for 5 cycles during RD_H0.
  - H0 is withheld for those 5 cycles; data stays stable under stall; no flit is lost or duplicated.
- **Reset mid-write:** assert `rst_n` low in WR_H2.
  - All outputs drop to 0; after release the state is IDLE and a new read completes normally.

Source files
------------

// File: rtl/noc_request_axi_if.sv
// noc_request_axi_if
// Bundles the AXI AR/AW/W request channels, the NoC request flit channel and
// the transaction-type FIFO write port of the request bridge.
//   slave  : bridge view (accepts AXI, drives NoC flits and type-FIFO writes)
//   master : environment view (accelerator AXI master, NoC router, type FIFO)
interface noc_request_axi_if #(
  parameter int AXI_ADDR_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]                s_axi_arlen;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]                s_axi_awlen;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [63:0]               s_axi_wdata;
  logic                      s_axi_wlast;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic                      noc_valid_out;
  logic [63:0]               noc_data_out;
  logic                      noc_ready_in;
  logic [5:0]                transaction_type_wr_data;
  logic                      transaction_type_wr;
  logic                      transaction_type_full;

  modport slave (
    input  s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output noc_valid_out, noc_data_out,
    input  noc_ready_in,
    output transaction_type_wr_data, transaction_type_wr,
    input  transaction_type_full
  );

  modport master (
    output s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  noc_valid_out, noc_data_out,
    output noc_ready_in,
    input  transaction_type_wr_data, transaction_type_wr,
    output transaction_type_full
  );
endinterface

// File: rtl/noc_request_axi.sv
// noc_request_axi
// AXI-to-OpenPiton request bridge. Each 8-byte AXI beat of an INCR burst on
// AR (or AW+W) becomes one NC load (3 flits) or NC store (4 flits) message,
// and a 6-bit transaction-info word is pushed into the type FIFO when the
// message's header 0 is accepted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : noc_request_axi_if.slave (AXI AR/AW/W, NoC flits, type FIFO)
module noc_request_axi #(
  parameter int          AXI_ADDR_WIDTH = 64,
  parameter int          AXI_DATA_WIDTH = 64,
  parameter logic [13:0] DEST_CHIPID    = 14'd0,
  parameter logic [7:0]  DEST_X         = 8'd0,
  parameter logic [7:0]  DEST_Y         = 8'd0,
  parameter logic [13:0] SRC_CHIPID     = 14'd0,
  parameter logic [7:0]  SRC_X          = 8'd0,
  parameter logic [7:0]  SRC_Y          = 8'd0,
  parameter logic [7:0]  MSHRID         = 8'd0
) (
  input logic                clk,
  input logic                rst_n,
  noc_request_axi_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RD_H0, RD_H1, RD_H2, WR_H0, WR_H1, WR_H2, WR_DATA
  } state_t;

  localparam logic [7:0] MSG_NC_LOAD  = 8'd14;
  localparam logic [7:0] MSG_NC_STORE = 8'd15;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic                      last_wr_q;   // last grant was the write channel

  logic                      grant_rd, grant_wr, fire, last_beat, is_store;
  logic [AXI_DATA_WIDTH-1:0] wdata, wdata_swap;
  logic [63:0]               hdr0, hdr1, hdr2;

  assign wdata = bus.s_axi_wdata;

  // NoC flits are big-endian relative to AXI little-endian beats.
  always_comb begin
    wdata_swap = '0;
    for (int b = 0; b < AXI_DATA_WIDTH / 8; b++)
      wdata_swap[8*b +: 8] = wdata[AXI_DATA_WIDTH-8-8*b +: 8];
  end

  // Round-robin only matters on a conflict; a lone request always wins.
  assign grant_rd = rst_n && (state_q == IDLE) && bus.s_axi_arvalid &&
                    (!bus.s_axi_awvalid || last_wr_q);
  assign grant_wr = rst_n && (state_q == IDLE) && bus.s_axi_awvalid &&
                    (!bus.s_axi_arvalid || !last_wr_q);

  assign is_store  = (state_q == WR_H0);
  assign last_beat = (cnt_q == len_q);

  assign hdr0 = {DEST_CHIPID, DEST_X, DEST_Y, 4'b0,
                 (is_store ? 8'd3 : 8'd2),
                 (is_store ? MSG_NC_STORE : MSG_NC_LOAD),
                 MSHRID, 6'b0};
  assign hdr1 = {addr_q[47:0], 2'b0, 3'b100, 11'b0};
  assign hdr2 = {SRC_CHIPID, SRC_X, SRC_Y, 34'b0};

  always_comb begin
    bus.noc_valid_out            = 1'b0;
    bus.noc_data_out             = '0;
    bus.s_axi_wready             = 1'b0;
    bus.transaction_type_wr_data = '0;
    unique case (state_q)
      RD_H0: begin
        bus.noc_valid_out            = !bus.transaction_type_full;
        bus.noc_data_out             = hdr0;
        bus.transaction_type_wr_data = {1'b0, last_beat, 1'b0, addr_q[3], 2'd1};
      end
      WR_H0: begin
        // Wait for W data before committing to the message, so the data
        // flit can never stall on an absent beat once headers are out.
        bus.noc_valid_out            = !bus.transaction_type_full && bus.s_axi_wvalid;
        bus.noc_data_out             = hdr0;
        bus.transaction_type_wr_data = {bus.s_axi_wlast, 1'b0, 1'b0, 1'b0, 2'd2};
      end
      RD_H1, WR_H1: begin
        bus.noc_valid_out = 1'b1;
        bus.noc_data_out  = hdr1;
      end
      RD_H2, WR_H2: begin
        bus.noc_valid_out = 1'b1;
        bus.noc_data_out  = hdr2;
      end
      WR_DATA: begin
        bus.noc_valid_out = 1'b1;
        bus.noc_data_out  = wdata_swap;
        bus.s_axi_wready  = bus.noc_ready_in;
      end
      default: ;
    endcase
  end

  assign fire                    = bus.noc_valid_out && bus.noc_ready_in;
  assign bus.s_axi_arready       = grant_rd;
  assign bus.s_axi_awready       = grant_wr;
  assign bus.transaction_type_wr = fire && (state_q == RD_H0 || state_q == WR_H0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_rd) begin
            addr_q    <= bus.s_axi_araddr;
            len_q     <= bus.s_axi_arlen;
            cnt_q     <= '0;
            last_wr_q <= 1'b0;
            state_q   <= RD_H0;
          end else if (grant_wr) begin
            addr_q    <= bus.s_axi_awaddr;
            len_q     <= bus.s_axi_awlen;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
            state_q   <= WR_H0;
          end
        end
        RD_H0:   if (fire) state_q <= RD_H1;
        RD_H1:   if (fire) state_q <= RD_H2;
        WR_H0:   if (fire) state_q <= WR_H1;
        WR_H1:   if (fire) state_q <= WR_H2;
        WR_H2:   if (fire) state_q <= WR_DATA;
        RD_H2, WR_DATA: begin
          if (fire) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_q + AXI_ADDR_WIDTH'(8);
              state_q <= (state_q == RD_H2) ? RD_H0 : WR_H0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_request_axi.sv
// tb_noc_request_axi
// Directed sequence plus randomized bursts for noc_request_axi. Expected
// flit streams and type-FIFO words come from a message-level model built from
// the header field layout; observed traffic is collected by a NoC-side monitor.
module tb_noc_request_axi;
  localparam logic [13:0] DCHIP = 14'h2A5B;
  localparam logic [7:0]  DX    = 8'h3C;
  localparam logic [7:0]  DY    = 8'hC3;
  localparam logic [13:0] SCHIP = 14'h1357;
  localparam logic [7:0]  SX    = 8'h5A;
  localparam logic [7:0]  SY    = 8'hA5;
  localparam logic [7:0]  MSHR  = 8'h77;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_request_axi_if #(.AXI_ADDR_WIDTH(64)) bus ();

  noc_request_axi #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
    .DEST_CHIPID(DCHIP), .DEST_X(DX), .DEST_Y(DY),
    .SRC_CHIPID(SCHIP), .SRC_X(SX), .SRC_Y(SY), .MSHRID(MSHR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] got_f[$], exp_f[$];
  logic [5:0]  got_t[$], exp_t[$];

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          last_fcyc = 0;
  int          w_hs = 0;
  int          stall_viol = 0;
  int          both_rdy = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  bit          rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(bus.noc_valid_out && bus.noc_data_out == prev_data))
        stall_viol <= stall_viol + 1;
      if (bus.noc_valid_out && bus.noc_ready_in) begin
        got_f.push_back(bus.noc_data_out);
        last_fcyc <= cyc;
      end
      if (bus.transaction_type_wr) got_t.push_back(bus.transaction_type_wr_data);
      if (bus.s_axi_wready && bus.s_axi_wvalid) w_hs <= w_hs + 1;
      if (bus.s_axi_arready && bus.s_axi_awready) both_rdy <= both_rdy + 1;
      prev_stall <= bus.noc_valid_out && !bus.noc_ready_in;
      prev_data  <= bus.noc_data_out;
    end
  end

  // NoC ready: held high, or random while rnd_ready is set.
  initial begin
    bus.noc_ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.noc_ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_h0(input bit st);
    return (64'(DCHIP) << 50) | (64'(DX) << 42) | (64'(DY) << 34) |
           ((st ? 64'd3 : 64'd2) << 22) | ((st ? 64'd15 : 64'd14) << 14) |
           (64'(MSHR) << 6);
  endfunction

  function automatic logic [63:0] m_h1(input logic [63:0] a);
    return (a << 16) | (64'd4 << 11);
  endfunction

  function automatic logic [63:0] m_h2();
    return (64'(SCHIP) << 50) | (64'(SX) << 42) | (64'(SY) << 34);
  endfunction

  function automatic logic [63:0] brev(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction

  task automatic exp_read(input logic [63:0] a, input int l);
    logic [63:0] ba;
    for (int b = 0; b <= l; b++) begin
      ba = a + 64'(8 * b);
      exp_f.push_back(m_h0(1'b0));
      exp_f.push_back(m_h1(ba));
      exp_f.push_back(m_h2());
      exp_t.push_back(6'((b == l ? 16 : 0) + (ba[3] ? 4 : 0) + 1));
    end
  endtask

  task automatic exp_write(input logic [63:0] a, input int l, input logic [63:0] d[$]);
    for (int b = 0; b <= l; b++) begin
      exp_f.push_back(m_h0(1'b1));
      exp_f.push_back(m_h1(a + 64'(8 * b)));
      exp_f.push_back(m_h2());
      exp_f.push_back(brev(d[b]));
      exp_t.push_back(6'((b == l ? 32 : 0) + 2));
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_flits();
    int t = 0;
    while (got_f.size() < exp_f.size() && t < 6000) begin
      @(posedge clk); t++;
    end
    chk("flit_timeout", 64'(got_f.size() >= exp_f.size()), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    int nf, nt;
    chk({tag, "_nflits"}, 64'(got_f.size()), 64'(exp_f.size()));
    chk({tag, "_ntypes"}, 64'(got_t.size()), 64'(exp_t.size()));
    nf = (got_f.size() < exp_f.size()) ? got_f.size() : exp_f.size();
    nt = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
    for (int i = 0; i < nf; i++) chk($sformatf("%s_flit%0d", tag, i), got_f[i], exp_f[i]);
    for (int i = 0; i < nt; i++) chk($sformatf("%s_type%0d", tag, i), 64'(got_t[i]), 64'(exp_t[i]));
    got_f.delete(); exp_f.delete(); got_t.delete(); exp_t.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"},  64'(bus.noc_valid_out), 64'd0);
    chk({tag, "_data"},   bus.noc_data_out, 64'd0);
    chk({tag, "_arrdy"},  64'(bus.s_axi_arready), 64'd0);
    chk({tag, "_awrdy"},  64'(bus.s_axi_awready), 64'd0);
    chk({tag, "_wrdy"},   64'(bus.s_axi_wready), 64'd0);
    chk({tag, "_twr"},    64'(bus.transaction_type_wr), 64'd0);
    chk({tag, "_tdata"},  64'(bus.transaction_type_wr_data), 64'd0);
  endtask

  // ---------------- AXI drivers ----------------
  int hs_cyc = 0;

  task automatic issue_read(input logic [63:0] a, input int l);
    int t = 0;
    bit g = 0;
    bus.s_axi_araddr  = a;
    bus.s_axi_arlen   = 8'(l);
    bus.s_axi_arvalid = 1'b1;
    while (!g && t < 200) begin
      @(negedge clk);
      if (bus.s_axi_arready) begin g = 1; hs_cyc = cyc; end
      @(posedge clk); #1;
      t++;
    end
    bus.s_axi_arvalid = 1'b0;
    chk("ar_grant", 64'(g), 64'd1);
    exp_read(a, l);
  endtask

  task automatic do_write(input logic [63:0] a, input int l, input logic [63:0] d[$]);
    int t = 0;
    int beat = 0;
    bit awg = 0;
    bit adv;
    bus.s_axi_awaddr  = a;
    bus.s_axi_awlen   = 8'(l);
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata   = d[0];
    bus.s_axi_wlast   = (l == 0);
    bus.s_axi_wvalid  = 1'b1;
    while (beat <= l && t < 3000) begin
      @(negedge clk);
      if (bus.s_axi_awready) awg = 1;
      adv = bus.s_axi_wready && bus.s_axi_wvalid;
      @(posedge clk); #1;
      if (awg) bus.s_axi_awvalid = 1'b0;
      if (adv) begin
        beat++;
        if (beat > l) bus.s_axi_wvalid = 1'b0;
        else begin
          bus.s_axi_wdata = d[beat];
          bus.s_axi_wlast = (beat == l);
        end
      end
      t++;
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    chk("w_beats_done", 64'(beat), 64'(l + 1));
    exp_write(a, l, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] dq[$];
    logic [63:0] a;
    int          l, nar, t, w0;
    bit          awg, wd;
    int          gq[$];

    bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.transaction_type_full = 1'b0;

    // Reset state.
    #12;
    chk_outputs_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration: simultaneous AR/AW twice -> read, write, then pending read.
    bus.s_axi_araddr = 64'h4000; bus.s_axi_arlen = 8'd0; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_awaddr = 64'h5008; bus.s_axi_awlen = 8'd0; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata  = 64'hDEAD_BEEF_0BAD_F00D; bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1;
    nar = 0; awg = 0; wd = 0; t = 0;
    while (!(nar == 2 && awg && wd) && t < 300) begin
      @(negedge clk);
      if (bus.s_axi_arready) begin nar++; gq.push_back(0); end
      if (bus.s_axi_awready) begin awg = 1; gq.push_back(1); end
      if (bus.s_axi_wready && bus.s_axi_wvalid) wd = 1;
      @(posedge clk); #1;
      if (nar == 2) bus.s_axi_arvalid = 1'b0;
      if (awg) bus.s_axi_awvalid = 1'b0;
      if (wd) bus.s_axi_wvalid = 1'b0;
      t++;
    end
    bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("arb_ngrants", 64'(gq.size()), 64'd3);
    if (gq.size() == 3) begin
      chk("arb_first_rd", 64'(gq[0]), 64'd0);
      chk("arb_second_wr", 64'(gq[1]), 64'd1);
      chk("arb_third_rd", 64'(gq[2]), 64'd0);
    end
    exp_read(64'h4000, 0);
    dq = '{64'hDEAD_BEEF_0BAD_F00D};
    exp_write(64'h5008, 0, dq);
    exp_read(64'h4000, 0);
    wait_flits();
    compare_all("arb");

    // Single read.
    issue_read(64'h1000, 0);
    wait_flits();
    chk("single_type_word", (exp_t.size() == 1) ? 64'(exp_t[0]) : 64'hX, 64'b010001);
    compare_all("single_rd");

    // Read burst with timing.
    issue_read(64'h2008, 3);
    wait_flits();
    chk("burst_cycles", 64'(last_fcyc - hs_cyc), 64'd12);
    compare_all("burst_rd");

    // Write burst.
    w0 = w_hs;
    dq = '{64'h0102030405060708, 64'h1112131415161718};
    do_write(64'h3000, 1, dq);
    wait_flits();
    chk("wready_pulses", 64'(w_hs - w0), 64'd2);
    chk("wr_data0_literal", (got_f.size() > 3) ? got_f[3] : 64'hX, 64'h0807060504030201);
    compare_all("burst_wr");

    // Back-pressure and type-FIFO full during RD_H0.
    rnd_ready = 1'b1;
    bus.transaction_type_full = 1'b1;
    issue_read(64'h7_0000_1238, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("full_hold_valid%0d", i), 64'(bus.noc_valid_out), 64'd0);
      chk($sformatf("full_hold_twr%0d", i), 64'(bus.transaction_type_wr), 64'd0);
      @(posedge clk); #1;
    end
    bus.transaction_type_full = 1'b0;
    wait_flits();
    compare_all("full_bp");

    // Randomized bursts under random back-pressure.
    for (int k = 0; k < 4; k++) begin
      a = {$urandom, $urandom} & ~64'h7;
      l = $urandom_range(0, 4);
      issue_read(a, l);
      wait_flits();
      compare_all($sformatf("rnd_rd%0d", k));
      a = {$urandom, $urandom} & ~64'h7;
      l = $urandom_range(0, 4);
      dq.delete();
      for (int b = 0; b <= l; b++) dq.push_back({$urandom, $urandom});
      do_write(a, l, dq);
      wait_flits();
      compare_all($sformatf("rnd_wr%0d", k));
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    // Max-length read wrapping the top of the address space.
    issue_read(64'hFFFF_FFFF_FFFF_FC00, 255);
    wait_flits();
    compare_all("len255_wrap");

    // Reset in WR_H2.
    bus.s_axi_awaddr = 64'h6000; bus.s_axi_awlen = 8'd1; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata  = 64'h55AA_55AA_55AA_55AA; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b1;
    awg = 0; t = 0;
    while (got_f.size() < 2 && t < 100) begin
      @(negedge clk);
      if (bus.s_axi_awready) awg = 1;
      @(posedge clk); #1;
      if (awg) bus.s_axi_awvalid = 1'b0;
      t++;
    end
    chk("rst_reached_h2", 64'(got_f.size()), 64'd2);
    rst_n = 1'b0;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    got_f.delete(); got_t.delete(); exp_f.delete(); exp_t.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    issue_read(64'h8018, 1);
    wait_flits();
    compare_all("post_rst_rd");

    // Global monitor checks.
    chk("stall_stability", 64'(stall_viol), 64'd0);
    chk("both_ready", 64'(both_rdy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
